// File: rtl/serial_nibble_loader_if.sv
// Serial-bit input and parallel-word output bundle for serial_nibble_loader.
interface serial_nibble_loader_if #(
    parameter int unsigned WIDTH = 4
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

    logic             sin_valid;
    logic             sin_bit;
    logic             sin_start;
    logic             sin_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             frame_err;
    logic [CNT_W-1:0] bit_cnt;

    // Driver side: feeds bits and consumes words.
    modport master (
        output sin_valid, sin_bit, sin_start, out_ready,
        input  sin_ready, out_data, out_valid, frame_err, bit_cnt
    );

    // Loader side.
    modport slave (
        input  sin_valid, sin_bit, sin_start, out_ready,
        output sin_ready, out_data, out_valid, frame_err, bit_cnt
    );
endinterface

// File: rtl/serial_nibble_loader.sv
// Assembles an LSB-first serial bit stream into WIDTH-bit words and
// buffers up to two completed words for a parallel valid/ready consumer.
module serial_nibble_loader #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    serial_nibble_loader_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned OCC_W = 2;

    logic [WIDTH-1:0] shreg_q, shreg_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] last_q;
    logic [WIDTH-1:0] word_c;
    logic             wr_ptr_q, rd_ptr_q;
    logic [OCC_W-1:0] occ_q;
    logic             frame_err_q, frame_err_n;
    logic             full_c, accept_c, push_c, pop_c;

    assign full_c   = (occ_q == OCC_W'(DEPTH));
    assign accept_c = bus.sin_valid && !full_c;
    assign pop_c    = (occ_q != '0) && bus.out_ready;

    // Next shift/count state and word completion for an accepted bit.
    always_comb begin
        shreg_n     = shreg_q;
        cnt_n       = cnt_q;
        frame_err_n = 1'b0;
        push_c      = 1'b0;
        word_c      = shreg_q;
        if (accept_c) begin
            if (bus.sin_start) begin
                // Realign: this bit is bit 0; any partial word is dropped.
                shreg_n     = WIDTH'(bus.sin_bit);
                cnt_n       = CNT_W'(1);
                frame_err_n = (cnt_q != '0);
            end else begin
                for (int unsigned i = 0; i < WIDTH; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        word_c[i] = bus.sin_bit;
                    end
                end
                if (cnt_q == CNT_W'(WIDTH - 1)) begin
                    push_c  = 1'b1;
                    cnt_n   = '0;
                    shreg_n = '0;
                end else begin
                    shreg_n = word_c;
                    cnt_n   = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    // Shift register, bit counter and error pulse.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shreg_q     <= '0;
            cnt_q       <= '0;
            frame_err_q <= 1'b0;
        end else begin
            shreg_q     <= shreg_n;
            cnt_q       <= cnt_n;
            frame_err_q <= frame_err_n;
        end
    end

    // Two-entry word FIFO with toggling pointers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            last_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            occ_q    <= '0;
        end else begin
            if (push_c) begin
                mem_q[wr_ptr_q] <= word_c;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_c) begin
                last_q   <= mem_q[rd_ptr_q];
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push_c, pop_c})
                2'b10:   occ_q <= occ_q + OCC_W'(1);
                2'b01:   occ_q <= occ_q - OCC_W'(1);
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Outputs decoded from registered state only.
    assign bus.sin_ready = !full_c;
    assign bus.out_valid = (occ_q != '0);
    assign bus.out_data  = (occ_q != '0) ? mem_q[rd_ptr_q] : last_q;
    assign bus.frame_err = frame_err_q;
    assign bus.bit_cnt   = cnt_q;
endmodule

// File: tb/tb_serial_nibble_loader.sv
// Self-checking bench for serial_nibble_loader (WIDTH=4).
module tb_serial_nibble_loader;
    localparam int unsigned W = 4;

    logic clk;
    logic reset;

    serial_nibble_loader_if #(.WIDTH(W)) bus ();

    serial_nibble_loader #(.WIDTH(W), .DEPTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: word queue plus partial word value and bit count.
    int q[$];
    int part;
    int mcnt;
    bit mfe;
    int rx[$];

    typedef struct {
        logic v, b, s, r;
        logic exp_ov;
        logic [3:0] exp_data;
        logic exp_rdy;
        logic exp_fe;
        int   exp_cnt;
    } vec_t;

    function automatic void check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        q.delete();
        part = 0;
        mcnt = 0;
        mfe  = 0;
    endtask

    task automatic model_update(input logic v, b, s, r);
        bit acc, pop;
        acc = v && (q.size() < 2);
        pop = (q.size() != 0) && r;
        mfe = 0;
        if (pop) void'(q.pop_front());
        if (acc) begin
            if (s) begin
                mfe  = (mcnt != 0);
                part = int'(b);
                mcnt = 1;
            end else begin
                part = part | (int'(b) << mcnt);
                mcnt++;
                if (mcnt == W) begin
                    q.push_back(part);
                    part = 0;
                    mcnt = 0;
                end
            end
        end
    endtask

    task automatic check_model();
        check("out_valid", int'(bus.out_valid), int'(q.size() != 0));
        if (q.size() != 0) check("out_data", int'(bus.out_data), q[0]);
        check("sin_ready", int'(bus.sin_ready), int'(q.size() < 2));
        check("bit_cnt", int'(bus.bit_cnt), mcnt);
        check("frame_err", int'(bus.frame_err), int'(mfe));
    endtask

    task automatic step(input logic v, b, s, r);
        @(negedge clk);
        bus.sin_valid = v;
        bus.sin_bit   = b;
        bus.sin_start = s;
        bus.out_ready = r;
        if (bus.out_valid && r) rx.push_back(int'(bus.out_data));
        @(posedge clk);
        model_update(v, b, s, r);
        #1;
        check_model();
    endtask

    task automatic send_word(input logic [3:0] w, input logic with_start, input logic r);
        for (int i = 0; i < 4; i++) step(1'b1, w[i], with_start && (i == 0), r);
    endtask

    task automatic check_rx(input string name, input int exp[$]);
        check({name, "_count"}, rx.size(), exp.size());
        for (int i = 0; i < exp.size() && i < rx.size(); i++) check(name, rx[i], exp[i]);
    endtask

    vec_t vecs[13];
    logic tgl;
    int   fe_seen;

    initial begin
        // Word D with immediate pop, then resync via start (word 9).
        vecs[0]  = '{1,1,0,1, 0,4'h0,1,0,1};
        vecs[1]  = '{1,0,0,1, 0,4'h0,1,0,2};
        vecs[2]  = '{1,1,0,1, 0,4'h0,1,0,3};
        vecs[3]  = '{1,1,0,1, 1,4'hD,1,0,0};
        vecs[4]  = '{0,0,0,1, 0,4'h0,1,0,0};
        vecs[5]  = '{1,1,0,1, 0,4'h0,1,0,1};
        vecs[6]  = '{1,1,0,1, 0,4'h0,1,0,2};
        vecs[7]  = '{1,1,1,1, 0,4'h0,1,1,1};
        vecs[8]  = '{1,0,0,1, 0,4'h0,1,0,2};
        vecs[9]  = '{1,0,0,1, 0,4'h0,1,0,3};
        vecs[10] = '{1,1,0,0, 1,4'h9,1,0,0};
        vecs[11] = '{0,0,0,0, 1,4'h9,1,0,0};
        vecs[12] = '{0,0,0,1, 0,4'h0,1,0,0};

        bus.sin_valid = 0; bus.sin_bit = 0; bus.sin_start = 0; bus.out_ready = 0;
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_out_data", int'(bus.out_data), 0);
        check("rst_sin_ready", int'(bus.sin_ready), 1);
        check("rst_bit_cnt", int'(bus.bit_cnt), 0);
        check("rst_frame_err", int'(bus.frame_err), 0);
        @(negedge clk);
        reset = 1'b1;

        // Table-driven vectors.
        for (int i = 0; i < 13; i++) begin
            step(vecs[i].v, vecs[i].b, vecs[i].s, vecs[i].r);
            check("tbl_out_valid", int'(bus.out_valid), int'(vecs[i].exp_ov));
            if (vecs[i].exp_ov) check("tbl_out_data", int'(bus.out_data), int'(vecs[i].exp_data));
            check("tbl_sin_ready", int'(bus.sin_ready), int'(vecs[i].exp_rdy));
            check("tbl_frame_err", int'(bus.frame_err), int'(vecs[i].exp_fe));
            check("tbl_bit_cnt", int'(bus.bit_cnt), vecs[i].exp_cnt);
        end

        // Backpressure: two words fill the buffer, held bits are refused.
        rx.delete();
        send_word(4'h3, 0, 0);
        send_word(4'hA, 0, 0);
        check("full_sin_ready", int'(bus.sin_ready), 0);
        repeat (3) step(1, 0, 0, 0);
        check("held_bit_cnt", int'(bus.bit_cnt), 0);
        step(0, 0, 0, 1);
        check("ready_after_pop", int'(bus.sin_ready), 1);
        repeat (2) step(0, 0, 0, 1);
        check_rx("bp_order", '{32'h3, 32'hA});

        // Continuous stream with out_ready toggling every cycle.
        rx.delete();
        tgl = 1'b1;
        foreach (vecs[k]) begin end
        for (int w = 0; w < 4; w++) begin
            for (int i = 0; i < 4; i++) begin
                logic [3:0] wd;
                wd = 4'(1 << w);
                step(1, wd[i], 0, tgl);
                tgl = ~tgl;
            end
        end
        repeat (4) step(0, 0, 0, 1);
        check_rx("stream_order", '{32'h1, 32'h2, 32'h4, 32'h8});

        // Asynchronous reset mid-word with a buffered word.
        send_word(4'h5, 0, 0);
        step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        check("pre_rst_bit_cnt", int'(bus.bit_cnt), 2);
        @(negedge clk);
        bus.sin_valid = 0;
        reset = 1'b0;
        #1;
        check("async_out_valid", int'(bus.out_valid), 0);
        check("async_sin_ready", int'(bus.sin_ready), 1);
        check("async_bit_cnt", int'(bus.bit_cnt), 0);
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        rx.delete();
        fe_seen = 0;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] wd;
            wd = 4'h6;
            step(1, wd[i], 0, 0);
            fe_seen += int'(bus.frame_err);
        end
        step(0, 0, 0, 1);
        step(0, 0, 0, 1);
        check("post_rst_fe", fe_seen, 0);
        check_rx("post_rst_word", '{32'h6});

        // Start on bit 0 of every word: no errors.
        rx.delete();
        fe_seen = 0;
        for (int w = 0; w < 3; w++) begin
            logic [3:0] wd;
            wd = (w == 0) ? 4'hF : (w == 1) ? 4'h0 : 4'h5;
            for (int i = 0; i < 4; i++) begin
                step(1, wd[i], i == 0, 1);
                fe_seen += int'(bus.frame_err);
            end
        end
        repeat (2) step(0, 0, 0, 1);
        check("start_fe", fe_seen, 0);
        check_rx("start_words", '{32'hF, 32'h0, 32'h5});

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            step(($urandom_range(3) != 0), 1'($urandom_range(1)),
                 ($urandom_range(7) == 0), 1'($urandom_range(1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
